// File: rtl/packet_deframer.sv
// packet_deframer: checks header/payload/footer framing, buffers the payload and replays it
// only after the footer passes. Footer checksum compare is built when PACKET_DEFRAMER_CHECKSUM_EN is defined.
module packet_deframer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 381,
    parameter int unsigned HEADER_WIDTH = 32,
    parameter int unsigned FOOTER_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  validIn,
    input  logic                  lastIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    output logic                  lastOut,
    output logic                  busy,
    output logic                  errOut,
    output logic [2:0]            errCode
);
    localparam int unsigned CntW   = $clog2(MEMORY_DEPTH + 1);
    localparam int unsigned AddrW  = $clog2(MEMORY_DEPTH);
    localparam logic [15:0] Magic  = 16'hA5A5;
    localparam logic [15:0] MaxLen = 16'(MEMORY_DEPTH);

    localparam logic [2:0] ErrMagic = 3'd1;
    localparam logic [2:0] ErrLen   = 3'd2;
    localparam logic [2:0] ErrRunt  = 3'd3;
    localparam logic [2:0] ErrCsum  = 3'd4;
    localparam logic [2:0] ErrBusy  = 3'd5;

    if (HEADER_WIDTH != DATA_WIDTH || FOOTER_WIDTH != DATA_WIDTH) begin : gWidthCheck
        $error("packet_deframer: header and footer widths must equal DATA_WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StPayload, StSend, StDiscard} stateT;

    stateT                 stateQ, stateD;
    logic [CntW-1:0]       lenQ, lenD;
    logic [CntW-1:0]       countQ, countD;
    logic [CntW-1:0]       rdPtrQ, rdPtrD;
    logic [DATA_WIDTH-1:0] dataOutD;
    logic                  validOutD, lastOutD, busyD, errOutD;
    logic [2:0]            errCodeD;
    logic                  wrEn;
    logic                  errHit;
    logic [2:0]            errVal;
    logic                  footerOk;
    logic [AddrW-1:0]      rdAddr;
    logic [DATA_WIDTH-1:0] rdData;
    logic [15:0]           hdrMagic, hdrLen;

    logic [DATA_WIDTH-1:0] buffer [MEMORY_DEPTH];

`ifdef PACKET_DEFRAMER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csumQ, csumD;
`endif

    assign hdrMagic = dataIn[HEADER_WIDTH-1 -: 16];
    assign hdrLen   = dataIn[15:0];
    // Word 0 is fetched on the footer edge so the first payload word lands one cycle later.
    assign rdAddr   = (stateQ == StSend) ? rdPtrQ[AddrW-1:0] : '0;
    assign rdData   = buffer[rdAddr];

    always_comb begin
        stateD    = stateQ;
        lenD      = lenQ;
        countD    = countQ;
        rdPtrD    = rdPtrQ;
        dataOutD  = dataOut;
        validOutD = validOut;
        lastOutD  = lastOut;
        busyD     = busy;
        errOutD   = 1'b0;
        errCodeD  = errCode;
        wrEn      = 1'b0;
        errHit    = 1'b0;
        errVal    = 3'd0;
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
        csumD     = csumQ;
        footerOk  = (csumQ[FOOTER_WIDTH-1:0] == dataIn[FOOTER_WIDTH-1:0]);
`else
        footerOk  = 1'b1;
`endif

        unique case (stateQ)
            StIdle: begin
                if (validIn) begin
                    if (lastIn) begin
                        errHit = 1'b1; errVal = ErrRunt;
                    end else if (hdrMagic != Magic) begin
                        errHit = 1'b1; errVal = ErrMagic;
                    end else if (hdrLen == 16'd0 || hdrLen > MaxLen) begin
                        errHit = 1'b1; errVal = ErrLen;
                    end else begin
                        lenD   = hdrLen[CntW-1:0];
                        countD = '0;
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
                        csumD  = '0;
`endif
                        stateD = StPayload;
                    end
                end
            end
            StPayload: begin
                if (validIn && !lastIn) begin
                    if (countQ == lenQ) begin
                        errHit = 1'b1; errVal = ErrRunt;
                    end else begin
                        wrEn   = 1'b1;
                        countD = countQ + CntW'(1);
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
                        csumD  = csumQ ^ dataIn;
`endif
                    end
                end else if (validIn) begin
                    if (countQ != lenQ) begin
                        errHit = 1'b1; errVal = ErrRunt;
                    end else if (!footerOk) begin
                        errHit = 1'b1; errVal = ErrCsum;
                    end else begin
                        stateD    = StSend;
                        dataOutD  = rdData;
                        validOutD = 1'b1;
                        busyD     = 1'b1;
                        lastOutD  = (lenQ == CntW'(1));
                        rdPtrD    = CntW'(1);
                    end
                end
            end
            StSend: begin
                if (validIn && lastIn) begin
                    errOutD  = 1'b1;
                    errCodeD = ErrBusy;
                end
                if (rdPtrQ == lenQ) begin
                    validOutD = 1'b0;
                    busyD     = 1'b0;
                    lastOutD  = 1'b0;
                    stateD    = StIdle;
                end else begin
                    dataOutD = rdData;
                    lastOutD = (rdPtrQ + CntW'(1) == lenQ);
                    rdPtrD   = rdPtrQ + CntW'(1);
                end
            end
            StDiscard: begin
                if (validIn && lastIn) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase

        // An error on the footer ends the frame; otherwise the rest of it must be skipped.
        if (errHit) begin
            errOutD  = 1'b1;
            errCodeD = errVal;
            stateD   = lastIn ? StIdle : StDiscard;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateQ   <= StIdle;
            lenQ     <= '0;
            countQ   <= '0;
            rdPtrQ   <= '0;
            dataOut  <= '0;
            validOut <= 1'b0;
            lastOut  <= 1'b0;
            busy     <= 1'b0;
            errOut   <= 1'b0;
            errCode  <= 3'd0;
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
            csumQ    <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            lenQ     <= lenD;
            countQ   <= countD;
            rdPtrQ   <= rdPtrD;
            dataOut  <= dataOutD;
            validOut <= validOutD;
            lastOut  <= lastOutD;
            busy     <= busyD;
            errOut   <= errOutD;
            errCode  <= errCodeD;
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
            csumQ    <= csumD;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (wrEn) buffer[countQ[AddrW-1:0]] <= dataIn;
    end

endmodule

// File: tb/tb_packet_deframer.sv
// Randomized bench for packet_deframer: a frame-level reference model judges each whole frame
// and predicts every output cycle by cycle.
module tb_packet_deframer;
    localparam int unsigned Depth = 381;
`ifdef PACKET_DEFRAMER_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    typedef logic [31:0] wordQ[$];
    typedef enum {MIdle, MCollect, MDrop} modeT;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] dataIn = '0;
    logic        validIn = 1'b0;
    logic        lastIn = 1'b0;
    logic [31:0] dataOut;
    logic        validOut, lastOut, busy, errOut;
    logic [2:0]  errCode;

    always #5 clock = ~clock;

    packet_deframer #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(Depth),
        .HEADER_WIDTH(32),
        .FOOTER_WIDTH(32)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .dataIn  (dataIn),
        .validIn (validIn),
        .lastIn  (lastIn),
        .dataOut (dataOut),
        .validOut(validOut),
        .lastOut (lastOut),
        .busy    (busy),
        .errOut  (errOut),
        .errCode (errCode)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    modeT        mode = MIdle;
    int          frameLen = 0;
    int          sendEdges = 0;
    wordQ        payload;
    wordQ        outQ;
    logic [2:0]  lastCode = 3'd0;
    logic        expErr = 1'b0;
    logic        expValid = 1'b0;
    logic        expLast = 1'b0;
    logic [31:0] expData = '0;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] xorOf(input wordQ q);
        logic [31:0] x = '0;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    task automatic modelReset();
        mode = MIdle;
        payload.delete();
        outQ.delete();
        sendEdges = 0;
        lastCode = 3'd0;
        expErr = 1'b0;
        expValid = 1'b0;
        expLast = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic [31:0] d, input logic l);
        logic [2:0] code = 3'd0;
        if (sendEdges > 0) begin
            sendEdges--;
            if (v && l) code = 3'd5;
        end else if (v) begin
            case (mode)
                MIdle: begin
                    if (l) code = 3'd3;
                    else if (d[31:16] != 16'hA5A5) begin code = 3'd1; mode = MDrop; end
                    else if (d[15:0] == 16'd0 || int'(d[15:0]) > int'(Depth)) begin
                        code = 3'd2; mode = MDrop;
                    end else begin
                        frameLen = int'(d[15:0]);
                        payload.delete();
                        mode = MCollect;
                    end
                end
                MCollect: begin
                    if (!l) begin
                        if (payload.size() == frameLen) begin code = 3'd3; mode = MDrop; end
                        else payload.push_back(d);
                    end else begin
                        mode = MIdle;
                        if (payload.size() != frameLen) code = 3'd3;
                        else if (CsumEn && xorOf(payload) != d) code = 3'd4;
                        else begin
                            outQ = payload;
                            sendEdges = frameLen;
                        end
                    end
                end
                default: if (l) mode = MIdle;
            endcase
        end
        expErr = (code != 3'd0);
        if (expErr) lastCode = code;
        if (outQ.size() > 0) begin
            expValid = 1'b1;
            expData  = outQ.pop_front();
            expLast  = (outQ.size() == 0);
        end else begin
            expValid = 1'b0;
            expLast  = 1'b0;
        end
    endtask

    task automatic checkOutputs();
        checkEq("validOut", 32'(validOut), 32'(expValid));
        checkEq("busy", 32'(busy), 32'(expValid));
        checkEq("lastOut", 32'(lastOut), 32'(expLast));
        checkEq("errOut", 32'(errOut), 32'(expErr));
        checkEq("errCode", 32'(errCode), 32'(lastCode));
        if (expValid) checkEq("dataOut", dataOut, expData);
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l);
        validIn = v;
        dataIn  = d;
        lastIn  = l;
        @(posedge clock);
        modelStep(v, d, l);
        #1;
        checkOutputs();
    endtask

    task automatic sendWords(input wordQ f, input int gapPct);
        foreach (f[i]) begin
            while ($urandom_range(99) < gapPct) step(1'b0, $urandom, 1'b0);
            step(1'b1, f[i], (i == f.size() - 1));
        end
    endtask

    task automatic buildFrame(output wordQ f, input logic [31:0] hdr, input int n,
                              input logic [31:0] flip, input bit seq);
        wordQ p;
        for (int i = 0; i < n; i++) p.push_back(seq ? 32'(i + 1) : $urandom);
        f.delete();
        f.push_back(hdr);
        foreach (p[i]) f.push_back(p[i]);
        f.push_back(xorOf(p) ^ flip);
    endtask

    task automatic waitIdle();
        int budget = 1000;
        while ((sendEdges > 0 || outQ.size() > 0) && budget > 0) begin
            step(1'b0, '0, 1'b0);
            budget--;
        end
        if (budget == 0) checkEq("waitIdle timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        wordQ f;
        wordQ g;
        modelReset();
        #12;
        checkEq("rst dataOut", dataOut, 32'd0);
        checkEq("rst validOut", 32'(validOut), 32'd0);
        checkEq("rst lastOut", 32'(lastOut), 32'd0);
        checkEq("rst busy", 32'(busy), 32'd0);
        checkEq("rst errOut", 32'(errOut), 32'd0);
        checkEq("rst errCode", 32'(errCode), 32'd0);
        resetn = 1'b1;
        step(1'b0, '0, 1'b0);

        // Good L=10 frame, payload 1..10, footer 0xB
        buildFrame(f, 32'hA5A5000A, 10, 32'd0, 1'b1);
        checkEq("tp1 footer", f[11], 32'h0000000B);
        sendWords(f, 0);
        waitIdle();

        // Bad magic, then good L=20
        buildFrame(f, 32'h5A5A0004, 4, 32'd0, 1'b0);
        sendWords(f, 0);
        buildFrame(f, 32'hA5A50014, 20, 32'd0, 1'b0);
        sendWords(f, 0);
        waitIdle();

        // L=382 and L=0 rejected, then full-depth frame
        buildFrame(f, 32'hA5A5017E, 1, 32'd0, 1'b0);
        sendWords(f, 0);
        buildFrame(f, 32'hA5A50000, 0, 32'd0, 1'b0);
        sendWords(f, 0);
        buildFrame(f, 32'hA5A5017D, 381, 32'd0, 1'b0);
        sendWords(f, 0);
        waitIdle();

        // Runt footer, then off-by-one footer
        buildFrame(f, 32'hA5A5000A, 8, 32'd0, 1'b0);
        sendWords(f, 0);
        buildFrame(f, 32'hA5A5000A, 10, 32'd1, 1'b0);
        sendWords(f, 0);
        waitIdle();

        // Frame arriving during replay is lost with error 5
        buildFrame(f, 32'hA5A50014, 20, 32'd0, 1'b0);
        sendWords(f, 0);
        buildFrame(g, 32'hA5A50005, 5, 32'd0, 1'b0);
        sendWords(g, 0);
        waitIdle();

        // Reset in the middle of replay
        buildFrame(f, 32'hA5A50014, 20, 32'd0, 1'b0);
        sendWords(f, 0);
        repeat (4) step(1'b0, '0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checkEq("midRst validOut", 32'(validOut), 32'd0);
        checkEq("midRst busy", 32'(busy), 32'd0);
        modelReset();
        #2 resetn = 1'b1;
        buildFrame(f, 32'hA5A5000A, 10, 32'd0, 1'b0);
        sendWords(f, 0);
        waitIdle();

        // Random frames, some malformed, some overlapping a replay
        for (int k = 0; k < 60; k++) begin
            int len  = int'($urandom_range(1, 24));
            int kind = int'($urandom_range(0, 9));
            int gap  = ($urandom_range(1) == 1) ? 30 : 0;
            case (kind)
                0: buildFrame(f, 32'h12340000 | 32'(len), len, 32'd0, 1'b0);
                1: buildFrame(f, 32'hA5A50000 | ($urandom_range(1) == 1 ? 32'd0 :
                              32'(Depth + 1 + $urandom_range(99))), len, 32'd0, 1'b0);
                2: buildFrame(f, 32'hA5A50000 | 32'(len), len - 1, 32'd0, 1'b0);
                3: buildFrame(f, 32'hA5A50000 | 32'(len), len + int'($urandom_range(1, 2)),
                              32'd0, 1'b0);
                4: buildFrame(f, 32'hA5A50000 | 32'(len), len, 32'd1 << $urandom_range(31), 1'b0);
                5: begin f.delete(); f.push_back(32'hA5A50000 | 32'(len)); end
                default: buildFrame(f, 32'hA5A50000 | 32'(len), len, 32'd0, 1'b0);
            endcase
            sendWords(f, gap);
            if ($urandom_range(3) != 0) waitIdle();
        end
        waitIdle();
        repeat (3) step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/packet_deframer.md
# packet_deframer

Receive-side counterpart of the packet framing block: accepts a framed word stream (header, payload, footer), checks the frame, buffers the payload and, once the whole frame has been received and checked, replays only the payload words.
- Store-and-forward: a payload is never emitted until its footer has passed.
- Malformed or colliding frames are dropped whole and reported on an error strobe.
- Sits at the ingress of the packet path, directly downstream of the link that carries frames produced by the framer.

## Interface
- DATA_WIDTH, 32, width of every stream word.
- MEMORY_DEPTH, 381, maximum payload length in words; also the payload buffer depth.
- HEADER_WIDTH, 32, header word width (equals DATA_WIDTH).
- FOOTER_WIDTH, 32, footer word width (equals DATA_WIDTH).
- clock  in  1  single clock; everything is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- dataIn  in  DATA_WIDTH  framed input word.
- validIn  in  1  dataIn is valid this cycle (no backpressure).
- lastIn  in  1  marks the footer word (last word of the frame).
- dataOut  out  DATA_WIDTH  payload output word, registered.
- validOut  out  1  dataOut is valid.
- lastOut  out  1  final payload word.
- busy  out  1  high while replaying a payload (SEND).
- errOut  out  1  one-cycle frame-rejected strobe.
- errCode  out  3  reason code, valid while errOut=1; holds its last value otherwise.

## Operation
- Frame format:
  - Header: [31:16] = 16'hA5A5 (magic); [15:0] = payload length L in words.
  - Payload: L words.
  - Footer: XOR of all L payload words; carries lastIn=1.
- Input words are consumed only when validIn=1.
- State machine:
  - IDLE: the accepted word is the header.
    - lastIn=1 → error 3.
    - Magic mismatch → error 1.
    - L==0 or L>MEMORY_DEPTH → error 2.
    - Otherwise latch L and the running checksum; → PAYLOAD.
  - PAYLOAD, non-last word:
    - count<L: write buffer[count], XOR into checksum, count++.
    - count==L: error 3, → DISCARD.
  - PAYLOAD, last word (footer):
    - count!=L → error 3.
    - Checksum mismatch → error 4.
    - Otherwise → SEND.
  - SEND: replay buffer[0..L-1], one word per cycle; lastOut with word L-1; then → IDLE.
    - Any validIn word arriving in SEND is discarded. A lastIn seen in SEND raises error 5, and the machine stays in SEND.
  - DISCARD: drop words until an accepted lastIn, then → IDLE. No second error is raised.
- Exit state after an error:
  - Error detected on a word with lastIn=1 → IDLE.
  - Error detected on any other word → DISCARD.
- Error codes: 1 bad magic, 2 bad length, 3 length mismatch/runt, 4 checksum, 5 frame lost while busy.
- Checksum and count are cleared on every header acceptance.

## Timing
- Reset values: dataOut=0, validOut=0, lastOut=0, busy=0, errOut=0, errCode=0; FSM=IDLE; count=0.
- Buffer contents are not reset.
- Output latency: the first payload word appears on dataOut/validOut the cycle after the footer edge.
- Replay takes exactly L consecutive cycles with validOut=1.
- busy is high for the same L cycles.
- errOut rises the cycle after the offending word's clock edge and lasts one cycle.
- A header arriving the cycle after lastOut is accepted normally (back-to-back frames, one idle gap).
- resetn asserted mid-frame or mid-replay: outputs clear immediately (asynchronously), no partial payload continues, and the next frame must start with a header.

## Configuration
- PACKET_DEFRAMER_CHECKSUM_EN defined: the footer is compared to the payload XOR; a mismatch produces error 4.
- Macro undefined: the footer value is ignored (only its position and lastIn are checked), error 4 is never produced, and no checksum register is built.

## Test plan
- Good frame, L=10, header 32'hA5A5000A, payloads 1..10, footer 32'h0000000B → 10 words 1..10 out starting 1 cycle after footer, lastOut with word 10, no errOut.
- Header 32'h5A5A0004 then 4 words plus footer → errOut with errCode=1, no validOut, next good L=20 frame passes.
- Header 32'hA5A5017E (L=382), then 0, then L=381 full frame → error 2 for the first, full 381-word replay for the last; stall-free.
- L=10 header but footer after 8 words → error 3 on the footer, return to IDLE; with checksum off-by-one footer → error 4 (only with PACKET_DEFRAMER_CHECKSUM_EN).
- Second complete frame driven during SEND of L=20 → error 5 at its lastIn; first payload emitted intact; second frame lost.
- resetn pulsed low at replay word 5 of L=20 → validOut=0 at once; following L=10 frame delivered correctly.
